// File: rtl/video_switch_sequencer.sv
// video_switch_sequencer: mutes video, applies new path settings, waits for
//   the analog path to settle, then unmutes. Every change goes through this path.
// Latency: LIVE config change -> mute at edge 1, pins at MUTE_CYCLES+2,
//   unmute at MUTE_CYCLES+SETTLE_CYCLES+3.
// Backpressure: none; requests are level inputs and are resampled when settings are applied.
//
// Ports:
//   clk_50mhz_in    system clock
//   reset           asynchronous, active-high reset
//   req_*           requested output enable (active low) and path settings
//   signal_present  input signal detected
//   video_format    detected input format code
//   video_oe_x      applied output enable (active low, registered)
//   hd_sd_x, rgb_comp_x, int_ext_x, norm_y_g  applied path settings (registered)
//   format_applied  format candidate latched at the last apply
//   busy            high while a mute/apply/settle sequence is in progress

module video_switch_sequencer #(
  parameter int unsigned MUTE_CYCLES       = 50000,
  parameter int unsigned SETTLE_CYCLES     = 2500000,
  parameter int unsigned FMT_STABLE_CYCLES = 100000
) (
  input  logic       clk_50mhz_in,
  input  logic       reset,
  input  logic       req_video_oe_x,
  input  logic       req_hd_sd_x,
  input  logic       req_rgb_comp_x,
  input  logic       req_int_ext_x,
  input  logic       req_norm_y_g,
  input  logic       signal_present,
  input  logic [7:0] video_format,
  output logic       video_oe_x,
  output logic       hd_sd_x,
  output logic       rgb_comp_x,
  output logic       int_ext_x,
  output logic       norm_y_g,
  output logic [7:0] format_applied,
  output logic       busy
);

  localparam int MUTE_W   = $clog2(MUTE_CYCLES) + 1;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int FMT_W    = $clog2(FMT_STABLE_CYCLES) + 1;

  // MUTE counts 0..MUTE_CYCLES-1; SETTLE counts 0..SETTLE_CYCLES and leaves
  // on the cycle after reaching the top, giving SETTLE_CYCLES+1 settle cycles.
  localparam logic [MUTE_W-1:0]   MUTE_LAST  = MUTE_W'(MUTE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_TOP = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [FMT_W-1:0]    FMT_TOP    = FMT_W'(FMT_STABLE_CYCLES);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_LIVE   = 3'd1,
    S_MUTE   = 3'd2,
    S_APPLY  = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t              state_q;
  logic                video_oe_x_q;
  logic                hd_sd_x_q;
  logic                rgb_comp_x_q;
  logic                int_ext_x_q;
  logic                norm_y_g_q;
  logic [7:0]          format_applied_q;
  logic                busy_q;
  logic [MUTE_W-1:0]   mute_cnt_q;
  logic [SETTLE_W-1:0] settle_cnt_q;

  // ---------------------------------------------------------------------
  // Format filter: a format is accepted only after it has been seen
  // unchanged for FMT_STABLE_CYCLES consecutive clocks.
  // ---------------------------------------------------------------------
  logic [7:0]       fmt_cand_q, fmt_cand_d;
  logic [FMT_W-1:0] fmt_cnt_q, fmt_cnt_d;
  logic             fmt_change;
  logic             fmt_stable;

  assign fmt_change = (video_format != fmt_cand_q);
  assign fmt_stable = (fmt_cnt_q == FMT_TOP);

  always_comb begin
    fmt_cand_d = fmt_cand_q;
    fmt_cnt_d  = fmt_cnt_q;
    if (fmt_change) begin
      fmt_cand_d = video_format;
      fmt_cnt_d  = '0;
    end else if (!fmt_stable) begin
      fmt_cnt_d = fmt_cnt_q + FMT_W'(1);
    end
  end

  always_ff @(posedge clk_50mhz_in or posedge reset) begin
    if (reset) begin
      fmt_cand_q <= 8'h00;
      fmt_cnt_q  <= '0;
    end else begin
      fmt_cand_q <= fmt_cand_d;
      fmt_cnt_q  <= fmt_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Decision terms
  // ---------------------------------------------------------------------
  logic [3:0] cfg_req;
  logic [3:0] cfg_app;
  logic       cfg_diff;
  logic       fmt_diff;
  logic       fmt_drop;
  logic       want_on;

  assign cfg_req  = {req_hd_sd_x, req_rgb_comp_x, req_int_ext_x, req_norm_y_g};
  assign cfg_app  = {hd_sd_x_q, rgb_comp_x_q, int_ext_x_q, norm_y_g_q};
  assign cfg_diff = (cfg_req != cfg_app);
  assign fmt_diff = fmt_stable && (fmt_cand_q != format_applied_q);
  // A stable format that is about to be replaced: stability drops next edge.
  assign fmt_drop = fmt_stable && fmt_change;
  assign want_on  = !req_video_oe_x && signal_present && fmt_stable;

  // ---------------------------------------------------------------------
  // Sequencer. Outputs are updated together with the state so every pin
  // is a flop and matches the state it belongs to.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_50mhz_in or posedge reset) begin
    if (reset) begin
      state_q          <= S_OFF;
      video_oe_x_q     <= 1'b1;
      hd_sd_x_q        <= 1'b0;
      rgb_comp_x_q     <= 1'b1;
      int_ext_x_q      <= 1'b0;
      norm_y_g_q       <= 1'b0;
      format_applied_q <= 8'h00;
      busy_q           <= 1'b0;
      mute_cnt_q       <= '0;
      settle_cnt_q     <= '0;
    end else begin
      case (state_q)
        S_OFF: begin
          // A pure config change while dark still goes through APPLY so the
          // pins track the request; SETTLE decides whether to unmute.
          if (want_on || cfg_diff) begin
            state_q <= S_APPLY;
            busy_q  <= 1'b1;
          end
        end

        S_LIVE: begin
          if (!signal_present || req_video_oe_x) begin
            state_q      <= S_OFF;
            video_oe_x_q <= 1'b1;
          end else if (cfg_diff || fmt_diff) begin
            state_q      <= S_MUTE;
            video_oe_x_q <= 1'b1;
            busy_q       <= 1'b1;
            mute_cnt_q   <= '0;
          end
        end

        S_MUTE: begin
          // Requests are not looked at here; APPLY picks up the latest ones.
          if (mute_cnt_q == MUTE_LAST) begin
            state_q <= S_APPLY;
          end else begin
            mute_cnt_q <= mute_cnt_q + MUTE_W'(1);
          end
        end

        S_APPLY: begin
          hd_sd_x_q        <= req_hd_sd_x;
          rgb_comp_x_q     <= req_rgb_comp_x;
          int_ext_x_q      <= req_int_ext_x;
          norm_y_g_q       <= req_norm_y_g;
          format_applied_q <= fmt_cand_q;
          settle_cnt_q     <= '0;
          state_q          <= S_SETTLE;
        end

        S_SETTLE: begin
          // Priority: signal loss, then config change, then format events.
          if (!signal_present) begin
            state_q <= S_OFF;
            busy_q  <= 1'b0;
          end else if (cfg_diff) begin
            state_q <= S_APPLY;
          end else if (fmt_drop) begin
            state_q <= S_OFF;
            busy_q  <= 1'b0;
          end else if (fmt_diff) begin
            state_q <= S_APPLY;
          end else if (settle_cnt_q == SETTLE_TOP) begin
            busy_q <= 1'b0;
            if (want_on) begin
              state_q      <= S_LIVE;
              video_oe_x_q <= 1'b0;
            end else begin
              state_q <= S_OFF;
            end
          end else begin
            settle_cnt_q <= settle_cnt_q + SETTLE_W'(1);
          end
        end

        default: begin
          state_q      <= S_OFF;
          video_oe_x_q <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign video_oe_x     = video_oe_x_q;
  assign hd_sd_x        = hd_sd_x_q;
  assign rgb_comp_x     = rgb_comp_x_q;
  assign int_ext_x      = int_ext_x_q;
  assign norm_y_g       = norm_y_g_q;
  assign format_applied = format_applied_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_video_switch_sequencer.sv
// tb_video_switch_sequencer: table-driven directed vectors, hand-written
//   corner sequences and randomized stimulus against a deadline-based model.
// Outputs are sampled on the falling clock edge; inputs change there too.

module tb_video_switch_sequencer;

  localparam int M = 4;
  localparam int S = 8;
  localparam int F = 3;

  // {oe, hd, rgb, ie, norm, busy, format_applied}
  localparam logic [13:0] RST_VEC = {6'b101000, 8'h00};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_oe, req_hd, req_rgb, req_ie, req_norm, sig;
  logic [7:0] fmt;
  logic       d_oe, d_hd, d_rgb, d_ie, d_norm, d_busy;
  logic [7:0] d_fa;

  video_switch_sequencer #(
    .MUTE_CYCLES      (M),
    .SETTLE_CYCLES    (S),
    .FMT_STABLE_CYCLES(F)
  ) dut (
    .clk_50mhz_in  (clk),
    .reset         (rst),
    .req_video_oe_x(req_oe),
    .req_hd_sd_x   (req_hd),
    .req_rgb_comp_x(req_rgb),
    .req_int_ext_x (req_ie),
    .req_norm_y_g  (req_norm),
    .signal_present(sig),
    .video_format  (fmt),
    .video_oe_x    (d_oe),
    .hd_sd_x       (d_hd),
    .rgb_comp_x    (d_rgb),
    .int_ext_x     (d_ie),
    .norm_y_g      (d_norm),
    .format_applied(d_fa),
    .busy          (d_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b_%h required %b_%h", name, act[13:8], act[7:0], exp[13:8], exp[7:0]);
  endtask

  function automatic logic [13:0] dut_vec();
    return {d_oe, d_hd, d_rgb, d_ie, d_norm, d_busy, d_fa};
  endfunction

  // ---------------------------------------------------------------------
  // Reference model: modes with absolute-edge deadlines, format stability
  // from the edge at which the current candidate was first seen.
  // ---------------------------------------------------------------------
  typedef enum int {MD_OFF, MD_LIVE, MD_MUTE, MD_APPLY, MD_SETTLE} md_t;

  md_t        m_mode;
  int         m_n, m_since, m_deadline;
  logic [7:0] m_cand, m_fa;
  logic       m_hd, m_rgb, m_ie, m_norm;

  task automatic mdl_reset();
    m_mode = MD_OFF; m_n = 0; m_since = 0; m_deadline = 0;
    m_cand = 8'h00; m_fa = 8'h00;
    m_hd = 1'b0; m_rgb = 1'b1; m_ie = 1'b0; m_norm = 1'b0;
  endtask

  function automatic logic [13:0] mdl_vec();
    logic b;
    b = (m_mode == MD_MUTE) || (m_mode == MD_APPLY) || (m_mode == MD_SETTLE);
    return {m_mode != MD_LIVE, m_hd, m_rgb, m_ie, m_norm, b, m_fa};
  endfunction

  task automatic mdl_step();
    logic stable, want, cdiff, fdiff, fdrop;
    m_n++;
    stable = (m_n - 1 - m_since) >= F;
    want   = !req_oe && sig && stable;
    cdiff  = {req_hd, req_rgb, req_ie, req_norm} != {m_hd, m_rgb, m_ie, m_norm};
    fdiff  = stable && (m_cand != m_fa);
    fdrop  = stable && (fmt != m_cand);
    case (m_mode)
      MD_OFF:  if (want || cdiff) m_mode = MD_APPLY;
      MD_LIVE: begin
        if (!sig || req_oe) m_mode = MD_OFF;
        else if (cdiff || fdiff) begin m_mode = MD_MUTE; m_deadline = m_n + M; end
      end
      MD_MUTE: if (m_n == m_deadline) m_mode = MD_APPLY;
      MD_APPLY: begin
        {m_hd, m_rgb, m_ie, m_norm} = {req_hd, req_rgb, req_ie, req_norm};
        m_fa = m_cand;
        m_mode = MD_SETTLE;
        m_deadline = m_n + S + 1;
      end
      MD_SETTLE: begin
        if (!sig) m_mode = MD_OFF;
        else if (cdiff) m_mode = MD_APPLY;
        else if (fdrop) m_mode = MD_OFF;
        else if (fdiff) m_mode = MD_APPLY;
        else if (m_n == m_deadline) m_mode = want ? MD_LIVE : MD_OFF;
      end
      default: m_mode = MD_OFF;
    endcase
    if (fmt != m_cand) begin m_cand = fmt; m_since = m_n; end
  endtask

  task automatic tick(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      if (rst) mdl_reset(); else mdl_step();
      @(negedge clk);
      check("model", dut_vec(), mdl_vec());
    end
  endtask

  task automatic set_in(input logic [5:0] b, input logic [7:0] f);
    {req_oe, req_hd, req_rgb, req_ie, req_norm, sig} = b;
    fmt = f;
  endtask

  // ---------------------------------------------------------------------
  // Directed vector table: inputs {oe_x, hd, rgb, ie, norm, sig}, format,
  // clocks to run, then expected {oe, hd, rgb, ie, norm, busy} and format.
  // ---------------------------------------------------------------------
  typedef struct {
    string      name;
    logic [5:0] in_bits;
    logic [7:0] in_fmt;
    int         clocks;
    logic [5:0] exp_bits;
    logic [7:0] exp_fa;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic [5:0] ib, input logic [7:0] f,
                              input int c, input logic [5:0] eb, input logic [7:0] ef);
    vec_t v;
    v.name = nm; v.in_bits = ib; v.in_fmt = f; v.clocks = c; v.exp_bits = eb; v.exp_fa = ef;
    return v;
  endfunction

  initial begin
    tbl.push_back(mk("boot_settle",  6'b001001, 8'h07, 14, 6'b101001, 8'h07));
    tbl.push_back(mk("boot_live",    6'b001001, 8'h07,  1, 6'b001000, 8'h07));
    tbl.push_back(mk("cfg_mute",     6'b011001, 8'h07,  1, 6'b101001, 8'h07));
    tbl.push_back(mk("cfg_wait",     6'b011001, 8'h07,  4, 6'b101001, 8'h07));
    tbl.push_back(mk("cfg_pins",     6'b011001, 8'h07,  1, 6'b111001, 8'h07));
    tbl.push_back(mk("cfg_settle",   6'b011001, 8'h07,  8, 6'b111001, 8'h07));
    tbl.push_back(mk("cfg_live",     6'b011001, 8'h07,  1, 6'b011000, 8'h07));
    tbl.push_back(mk("glitch",       6'b011001, 8'h03,  2, 6'b011000, 8'h07));
    tbl.push_back(mk("glitch_back",  6'b011001, 8'h07,  6, 6'b011000, 8'h07));
    tbl.push_back(mk("fmt_hold",     6'b011001, 8'h03,  4, 6'b011000, 8'h07));
    tbl.push_back(mk("fmt_mute",     6'b011001, 8'h03,  1, 6'b111001, 8'h07));
    tbl.push_back(mk("fmt_wait",     6'b011001, 8'h03,  4, 6'b111001, 8'h07));
    tbl.push_back(mk("fmt_apply",    6'b011001, 8'h03,  1, 6'b111001, 8'h03));
    tbl.push_back(mk("fmt_settle",   6'b011001, 8'h03,  8, 6'b111001, 8'h03));
    tbl.push_back(mk("fmt_live",     6'b011001, 8'h03,  1, 6'b011000, 8'h03));
    tbl.push_back(mk("los_live",     6'b011000, 8'h03,  1, 6'b111000, 8'h03));
    tbl.push_back(mk("los_reacq",    6'b011001, 8'h03,  3, 6'b111001, 8'h03));
    tbl.push_back(mk("los_settle",   6'b011000, 8'h03,  1, 6'b111000, 8'h03));
    tbl.push_back(mk("reacq",        6'b011001, 8'h03, 10, 6'b111001, 8'h03));
    tbl.push_back(mk("reacq_live",   6'b011001, 8'h03,  1, 6'b011000, 8'h03));
    tbl.push_back(mk("dark_off",     6'b111001, 8'h03,  1, 6'b111000, 8'h03));
    tbl.push_back(mk("dark_track",   6'b111011, 8'h03,  2, 6'b111011, 8'h03));
    tbl.push_back(mk("dark_settle",  6'b111011, 8'h03,  8, 6'b111011, 8'h03));
    tbl.push_back(mk("dark_off2",    6'b111011, 8'h03,  1, 6'b111010, 8'h03));
    tbl.push_back(mk("dark_stay",    6'b111011, 8'h03,  3, 6'b111010, 8'h03));
    tbl.push_back(mk("wake",         6'b011011, 8'h03, 10, 6'b111011, 8'h03));
    tbl.push_back(mk("wake_live",    6'b011011, 8'h03,  1, 6'b011010, 8'h03));
    tbl.push_back(mk("prio_los_cfg", 6'b011110, 8'h03,  1, 6'b111010, 8'h03));
    tbl.push_back(mk("prio_track",   6'b011110, 8'h03,  2, 6'b111111, 8'h03));
    tbl.push_back(mk("prio_off",     6'b011110, 8'h03,  1, 6'b111110, 8'h03));
    tbl.push_back(mk("restore",      6'b011111, 8'h03, 10, 6'b111111, 8'h03));
    tbl.push_back(mk("restore_live", 6'b011111, 8'h03,  1, 6'b011110, 8'h03));

    // Reset with signal present and format 0x07 waiting.
    mdl_reset();
    rst = 1'b0;
    set_in(6'b001001, 8'h07);
    #2 rst = 1'b1;
    #1 check("reset_async", dut_vec(), RST_VEC);
    tick(2);
    check("reset_hold", dut_vec(), RST_VEC);
    rst = 1'b0;

    foreach (tbl[i]) begin
      set_in(tbl[i].in_bits, tbl[i].in_fmt);
      tick(tbl[i].clocks);
      check(tbl[i].name, dut_vec(), {tbl[i].exp_bits, tbl[i].exp_fa});
    end

    // Re-request during SETTLE: change int_ext, then rgb at settle count 5.
    set_in(6'b011011, 8'h03);
    tick(1);
    check("rereq_mute", dut_vec(), {6'b111111, 8'h03});
    tick(5);
    check("rereq_first_apply", dut_vec(), {6'b111011, 8'h03});
    tick(5);
    set_in(6'b010011, 8'h03);
    tick(1);
    check("rereq_apply_state", dut_vec(), {6'b111011, 8'h03});
    tick(1);
    check("rereq_rgb", dut_vec(), {6'b110011, 8'h03});
    tick(8);
    check("rereq_still_muted", dut_vec(), {6'b110011, 8'h03});
    tick(1);
    check("rereq_unmute", dut_vec(), {6'b010010, 8'h03});

    // Async reset between edges while in MUTE.
    set_in(6'b000011, 8'h03);
    tick(2);
    check("mute_before_reset", dut_vec(), {6'b110011, 8'h03});
    #2 rst = 1'b1;
    mdl_reset();
    #1 check("reset_mid_mute", dut_vec(), RST_VEC);
    tick(2);
    rst = 1'b0;

    // Randomized traffic against the model.
    set_in(6'b001001, 8'h07);
    for (int c = 0; c < 3000; c++) begin
      int r;
      int k;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        case ($urandom_range(0, 3))
          0: req_hd   = ~req_hd;
          1: req_rgb  = ~req_rgb;
          2: req_ie   = ~req_ie;
          default: req_norm = ~req_norm;
        endcase
      end else if (r < 6) begin
        req_oe = ~req_oe;
      end else if (r < 8) begin
        sig = ~sig;
      end else if (r < 11) begin
        k = $urandom_range(0, 2);
        fmt = (k == 0) ? 8'h07 : (k == 1) ? 8'h03 : 8'h55;
      end
      tick(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
